// File: rtl/bbox_pkg.sv
// Shared types and constants for the bounding-box tracker: coordinate width,
// frame limits, FSM encoding and the latched result record.
package bbox_pkg;

  localparam int COORD_W = 9;

  typedef logic [COORD_W-1:0] coord_t;

  localparam coord_t X_LAST = 9'd319;
  localparam coord_t Y_LAST = 9'd239;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_DONE,
    CAPTURE,
    ACK
  } state_t;

  typedef struct packed {
    coord_t x_min;
    coord_t x_max;
    coord_t y_min;
    coord_t y_max;
    coord_t center_x;
    coord_t center_y;
    coord_t w;
    coord_t h;
    logic   valid;
  } box_result_t;

  function automatic coord_t clamp(input coord_t v, input coord_t limit);
    return (v > limit) ? limit : v;
  endfunction

endpackage

// File: rtl/bbox_math.sv
// Combinational box conditioning: clamp to the frame, detect empty boxes,
// and derive centre and size from the clamped corners.
module bbox_math
  import bbox_pkg::*;
(
  input  logic [COORD_W-1:0] x_min,
  input  logic [COORD_W-1:0] x_max,
  input  logic [COORD_W-1:0] y_min,
  input  logic [COORD_W-1:0] y_max,
  output box_result_t        result
);

  coord_t          cx_min, cx_max, cy_min, cy_max;
  logic [COORD_W:0] sum_x, sum_y;
  logic            empty;

  assign cx_min = clamp(x_min, X_LAST);
  assign cx_max = clamp(x_max, X_LAST);
  assign cy_min = clamp(y_min, Y_LAST);
  assign cy_max = clamp(y_max, Y_LAST);

  // One extra bit so the midpoint of two large coordinates cannot wrap.
  assign sum_x = {1'b0, cx_min} + {1'b0, cx_max};
  assign sum_y = {1'b0, cy_min} + {1'b0, cy_max};

  assign empty = (cx_max < cx_min) || (cy_max < cy_min) ||
                 ((cx_max == '0) && (cy_max == '0));

  always_comb begin
    // NOTE: every field gets a default first so no path can infer a latch.
    result       = '0;
    result.x_min = cx_min;
    result.x_max = cx_max;
    result.y_min = cy_min;
    result.y_max = cy_max;
    if (!empty) begin
      result.center_x = COORD_W'(sum_x >> 1);
      result.center_y = COORD_W'(sum_y >> 1);
      result.w        = cx_max - cx_min;
      result.h        = cy_max - cy_min;
      result.valid    = 1'b1;
    end
  end

endmodule

// File: rtl/bbox_tracker.sv
// Frame-rate scan sequencer for the detection filter: start/done/ack handshake,
// result capture, one-deep request buffering, watchdog and sticky error flags.
module bbox_tracker
  import bbox_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               frame_tick,
  input  logic               clear_err,
  output logic               start_flag,
  output logic               ack_flag,
  input  logic               done_flag,
  input  logic [COORD_W-1:0] x_min,
  input  logic [COORD_W-1:0] x_max,
  input  logic [COORD_W-1:0] y_min,
  input  logic [COORD_W-1:0] y_max,
  output logic [COORD_W-1:0] box_x_min,
  output logic [COORD_W-1:0] box_x_max,
  output logic [COORD_W-1:0] box_y_min,
  output logic [COORD_W-1:0] box_y_max,
  output logic [COORD_W-1:0] center_x,
  output logic [COORD_W-1:0] center_y,
  output logic [COORD_W-1:0] box_w,
  output logic [COORD_W-1:0] box_h,
  output logic               box_valid,
  output logic               update_pulse,
  output logic               timeout,
  output logic               overrun,
  output logic [15:0]        frame_count
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic             pending;
  logic [CNT_W-1:0] cnt;
  box_result_t      math_res;
  box_result_t      res_q;
  logic             tick_ok;

  bbox_math u_math (
    .x_min  (x_min),
    .x_max  (x_max),
    .y_min  (y_min),
    .y_max  (y_max),
    .result (math_res)
  );

  assign tick_ok = frame_tick && enable;

  always_ff @(posedge clk) begin
    // NOTE: synchronous reset clears every register, result record included.
    if (reset) begin
      state        <= IDLE;
      pending      <= 1'b0;
      cnt          <= '0;
      res_q        <= '0;
      start_flag   <= 1'b0;
      ack_flag     <= 1'b0;
      update_pulse <= 1'b0;
      timeout      <= 1'b0;
      overrun      <= 1'b0;
      frame_count  <= '0;
    end else begin
      update_pulse <= 1'b0;

      // Clear first; error events below override it in the same cycle.
      if (clear_err) begin
        timeout <= 1'b0;
        overrun <= 1'b0;
      end

      // START consumes the pending request, so a tick landing there re-arms it cleanly.
      if (tick_ok) begin
        if (pending && (state != START)) overrun <= 1'b1;
        pending <= 1'b1;
      end else if (state == START) begin
        pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pending && enable && !done_flag) begin
            start_flag <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          start_flag <= 1'b0;
          cnt        <= '0;
          state      <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (done_flag) begin
            state <= CAPTURE;
          end else if (cnt == CNT_LAST) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        CAPTURE: begin
          res_q        <= math_res;
          update_pulse <= 1'b1;
          frame_count  <= frame_count + 16'd1;
          ack_flag     <= 1'b1;
          cnt          <= '0;
          state        <= ACK;
        end
        ACK: begin
          if (!done_flag) begin
            ack_flag <= 1'b0;
            state    <= IDLE;
          end else if (cnt == CNT_LAST) begin
            timeout  <= 1'b1;
            ack_flag <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign box_x_min = res_q.x_min;
  assign box_x_max = res_q.x_max;
  assign box_y_min = res_q.y_min;
  assign box_y_max = res_q.y_max;
  assign center_x  = res_q.center_x;
  assign center_y  = res_q.center_y;
  assign box_w     = res_q.w;
  assign box_h     = res_q.h;
  assign box_valid = res_q.valid;

endmodule
